// File: rtl/fifo_wr_ctrl_if.sv
// fifo_wr_ctrl_if: producer handshake, status and RAM write port of the FIFO write side
interface fifo_wr_ctrl_if #(
    parameter int W_ADDR = 4,
    parameter int W_DATA = 8
);
    logic              push;
    logic [W_DATA-1:0] data_in;
    logic              full;
    logic              almost_full;
    logic [W_ADDR:0]   level;
    logic              en_wr;
    logic [W_ADDR-1:0] addr_wr;
    logic [W_DATA-1:0] data_wr;
    modport master (
        output push, data_in,
        input  full, almost_full, level, en_wr, addr_wr, data_wr
    );
    modport slave (
        input  push, data_in,
        output full, almost_full, level, en_wr, addr_wr, data_wr
    );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: dual-clock FIFO write-side pointer/flag controller; optional overflow counter under FIFO_WR_OVF_CNT_EN
module fifo_wr_ctrl #(
    parameter int W_ADDR      = 4,
    parameter int W_DATA      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AF_LEVEL    = 12
) (
    input  logic            clk_wr,
    input  logic            rst_n,
    fifo_wr_ctrl_if.slave   bus,
    input  logic [W_ADDR:0] rd_ptr_gray_i,
    output logic [W_ADDR:0] wr_ptr_gray_o
`ifdef FIFO_WR_OVF_CNT_EN
    ,
    output logic            ovf_o,
    output logic [7:0]      ovf_cnt_o
`endif
);
    localparam logic [W_ADDR+1:0] AF = (W_ADDR+2)'(AF_LEVEL);
    logic [W_ADDR:0] sync_q [SYNC_STAGES];
    logic [W_ADDR:0] wr_bin_q, wr_bin_d, wr_gray_q, gn, rq, rd_bin, level_q, level_d;
    logic            full_q, af_q, acc;
    assign rq = sync_q[SYNC_STAGES-1];
    // accept decision and next-state pointer/level terms; en_wr is forced low while in reset
    always_comb begin
        acc      = bus.push & ~full_q & rst_n;
        wr_bin_d = wr_bin_q + {{W_ADDR{1'b0}}, acc};
        gn       = wr_bin_d ^ (wr_bin_d >> 1);
        rd_bin   = '0;
        for (int i = 0; i <= W_ADDR; i++) rd_bin[i] = ^(rq >> i);
        level_d  = wr_bin_d - rd_bin;
    end
    assign bus.en_wr       = acc;
    assign bus.addr_wr     = wr_bin_q[W_ADDR-1:0];
    assign bus.data_wr     = bus.data_in;
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.level       = level_q;
    assign wr_ptr_gray_o   = wr_gray_q;
    // pointers, read-pointer synchroniser and registered flags; full compares against rq with top two bits inverted
    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            wr_bin_q  <= '0;
            wr_gray_q <= '0;
            full_q    <= 1'b0;
            af_q      <= 1'b0;
            level_q   <= '0;
        end else begin
            sync_q[0] <= rd_ptr_gray_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            wr_bin_q  <= wr_bin_d;
            wr_gray_q <= gn;
            full_q    <= gn == {~rq[W_ADDR:W_ADDR-1], rq[W_ADDR-2:0]};
            af_q      <= {1'b0, level_d} >= AF;
            level_q   <= level_d;
        end
    end
`ifdef FIFO_WR_OVF_CNT_EN
    logic       ovf_q;
    logic [7:0] ovf_cnt_q;
    assign ovf_o     = ovf_q;
    assign ovf_cnt_o = ovf_cnt_q;
    // sticky overflow flag and saturating count of pushes dropped while full
    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else if (bus.push & full_q) begin
            ovf_q     <= 1'b1;
            ovf_cnt_q <= ovf_cnt_q == 8'hff ? ovf_cnt_q : ovf_cnt_q + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: directed spec scenarios plus random push/read traffic against a count-based reference model
module tb_fifo_wr_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rd_ptr_gray = '0;
    logic [4:0] wr_ptr_gray;
`ifdef FIFO_WR_OVF_CNT_EN
    logic       ovf;
    logic [7:0] ovf_cnt;
`endif
    int checks = 0, failures = 0;
    int m_wr = 0, m_s0 = 0, m_s1 = 0, m_ovf_cnt = 0;
    logic m_full = 0, m_af = 0, m_ovf = 0;
    int rdc;

    fifo_wr_ctrl_if #(.W_ADDR(4), .W_DATA(8)) bus ();

    fifo_wr_ctrl #(.W_ADDR(4), .W_DATA(8), .SYNC_STAGES(2), .AF_LEVEL(12)) dut (
        .clk_wr        (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .rd_ptr_gray_i (rd_ptr_gray),
        .wr_ptr_gray_o (wr_ptr_gray)
`ifdef FIFO_WR_OVF_CNT_EN
        ,
        .ovf_o         (ovf),
        .ovf_cnt_o     (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4:0] g5(input int v);
        logic [4:0] b;
        b = 5'(v);
        return b ^ (b >> 1);
    endfunction

    // one clk_wr cycle: drive at posedge+1, check RAM port, clock, advance model, check flags
    task automatic step(input logic p, input int r);
        logic [7:0] d;
        logic acc;
        int lvl;
        d = 8'($urandom);
        bus.push = p;
        bus.data_in = d;
        rd_ptr_gray = g5(r);
        #1;
        chk("en_wr", bus.en_wr, p & ~m_full);
        chk("addr_wr", bus.addr_wr, m_wr % 16);
        chk("data_wr", bus.data_wr, d);
        @(posedge clk);
        acc = p & ~m_full;
        if (p & m_full) begin
            m_ovf = 1;
            if (m_ovf_cnt < 255) m_ovf_cnt++;
        end
        m_wr += acc;
        lvl = m_wr - m_s1;
        m_full = lvl == 16;
        m_af = lvl >= 12;
        m_s1 = m_s0;
        m_s0 = r;
        #1;
        chk("full", bus.full, m_full);
        chk("almost_full", bus.almost_full, m_af);
        chk("level", bus.level, lvl);
        chk("wr_ptr_gray", wr_ptr_gray, g5(m_wr));
`ifdef FIFO_WR_OVF_CNT_EN
        chk("ovf", ovf, m_ovf);
        chk("ovf_cnt", ovf_cnt, m_ovf_cnt);
`endif
    endtask

    initial begin
        bus.push = 0;
        bus.data_in = '0;
        #1;
        chk("rst_full", bus.full, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_gray", wr_ptr_gray, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) step(1, 0);
        bus.push = 1;
        rst_n = 0;
        #1;
        chk("midrst_en_wr", bus.en_wr, 0);
        chk("midrst_full", bus.full, 0);
        chk("midrst_level", bus.level, 0);
        chk("midrst_gray", wr_ptr_gray, 0);
        m_wr = 0; m_s0 = 0; m_s1 = 0; m_full = 0; m_af = 0; m_ovf = 0; m_ovf_cnt = 0;
        bus.push = 0;
        #2;
        rst_n = 1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 16; i++) begin
            step(1, 0);
            chk("fill_af", bus.almost_full, i >= 12);
        end
        chk("fill_full", bus.full, 1);
        chk("fill_level", bus.level, 16);
        chk("fill_gray", wr_ptr_gray, 5'b11000);
        for (int i = 0; i < 3; i++) step(1, 0);
        chk("ovf_gray", wr_ptr_gray, 5'b11000);
`ifdef FIFO_WR_OVF_CNT_EN
        chk("ovf_flag", ovf, 1);
        chk("ovf_count", ovf_cnt, 3);
`endif
        for (int i = 0; i < 3; i++) step(0, 4);
        chk("drain_full", bus.full, 0);
        chk("drain_level", bus.level, 12);
        chk("drain_af", bus.almost_full, 1);
        for (int i = 0; i < 20; i++) begin
            step(1, 5 + i);
            chk("wrap_nofull", bus.full, 0);
        end
        chk("wrap_gray", wr_ptr_gray, 5'b00110);
        for (int i = 0; i < 3; i++) step(0, 24);
        chk("idle_level", bus.level, 12);
        step(0, 25);
        step(0, 25);
        step(1, 25);
        chk("simul_level", bus.level, 12);
        chk("simul_full", bus.full, 0);
        rdc = 25;
        for (int i = 0; i < 400; i++) begin
            if (rdc < m_wr && $urandom_range(0, 2) == 0) rdc++;
            step($urandom_range(0, 3) != 0, rdc);
        end
        for (int i = 0; i < 300; i++) begin
            if (rdc < m_wr && $urandom_range(0, 1) == 0) rdc++;
            step($urandom_range(0, 2) == 0, rdc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
